logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational bitwise logic unit.
- Takes one operand pair plus an opcode per transaction over a valid/ready handshake and returns one registered result with status flags, 2 cycles later.
- Adds shift/rotate ops, an accumulator-chaining mode, an illegal-opcode error flag and a completed-transaction counter.
- Sits beside the adder/ALU datapath; the ALU top muxes its result.

Parameters:
- W, 16, operand/result width in bits (W >= 2, power of two).
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request this cycle
- in_op  in  4  opcode (see Behaviour)
- in_a  in  W  operand A
- in_b  in  W  operand B; for shift/rotate ops only B[$clog2(W)-1:0] is used
- in_use_acc  in  1  replace A with accumulator at compute time
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  W  result
- out_zero  out  1  result == 0
- out_ones  out  1  result == all ones
- out_parity  out  1  XOR-reduction of result
- out_err  out  1  opcode was illegal (12-15)
- op_count  out  CNT_W  number of results accepted by the consumer, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high, sampled on the rising edge of clk.
- Opcodes:
  - 0 AND, 1 OR, 2 XOR
  - 3 NOT (bitwise ~A; B ignored)
  - 4 NOR, 5 XNOR, 6 NAND
  - 7 PASS A
  - 8 SHL, 9 SHR (logical, zero fill)
  - 10 ROL, 11 ROR; shift amount is B mod W
  - 12-15 illegal: result 0, out_err=1
- Pipeline: stage S1 registers (op, a, b, use_acc). Stage S2 computes combinationally from S1 and registers result and flags.
- Latency: request accepted at edge N appears on the outputs after edge N+1, i.e. 2 cycles, when out_ready is high.
- Throughput: 1 transaction/cycle when out_ready stays high.
- Handshake:
  - A transfer occurs when valid && ready are both high at the rising edge.
  - s2_adv = !out_valid || out_ready
  - s1_adv = s1_valid && s2_adv
  - in_ready = !s1_valid || s2_adv (combinational; no dependence on in_valid)
- Held output: while out_valid && !out_ready, out_result and all flags are held stable. No transaction is dropped or duplicated.
- Accumulator:
  - acc register, W bits, reset 0. Loaded with the computed result on every S1->S2 advance, including illegal ops (which load 0).
  - A_eff = S1.use_acc ? acc : S1.a.
  - Back-to-back chained ops therefore always see the immediately preceding op's result; no bubble is required.
- Flags: derived from the registered result; out_err is registered with it.
- op_count: increments on each out_valid && out_ready cycle and wraps from 2^CNT_W-1 to 0.
- Reset values:
  - in_ready=1 after the reset edge; s1_valid=0.
  - out_valid=0, out_result=0.
  - out_zero=1, out_ones=0, out_parity=0, out_err=0.
  - acc=0, op_count=0.
- Reset mid-operation: any in-flight transactions are discarded and no output handshake is produced for them. rst has priority over all transfers in the same cycle.
- Simultaneous events: an S2 drain, an S1->S2 advance and a new input accept may all occur in the same cycle.
- Shift boundaries:
  - Shift amount 0 returns A_eff unchanged.
  - Shift amount W-1 is the maximum.
  - Bits of B above $clog2(W) are ignored.

Decomposition:
- Shared package logic_pkg holds:
  - opcode localparams (OP_AND..OP_ROR, OP_ILLEGAL_MIN=12)
  - a function is_legal_op
- The datapath is one natural sub-module, logic_unit_core: purely combinational (op, a, b) -> (result, err). It generalises the old bitwise block, and the top keeps the pipeline/handshake, acc and counter.

Test Plan:
- W=16, out_ready=1, A=16'hABAB, B=16'h5757, ops 0-6 back-to-back:
  - results AND 0303, OR FFFF, XOR FCFC, NOT 5454, NOR 0000, XNOR 0303, NAND FCFC, one per cycle starting 2 cycles after the first accept.
  - NOR has out_zero=1; OR has out_ones=1.
  - op_count=7 at the end.
- Shifts, A=16'h8001:
  - SHL B=1 -> 0002
  - ROL B=1 -> 0003
  - ROR B=17 (amount 1) -> C000
  - SHR B=0 -> 8001
- Chaining:
  - PASS A=00F0 then OR use_acc=1 B=000F -> 00FF.
  - Then XOR use_acc=1 B=00FF -> 0000 with out_zero=1, issued back-to-back with no stall.
- Backpressure:
  - Hold out_ready=0 for 5 cycles while streaming 4 requests. in_ready drops after 2 accepts, out_result stays constant.
  - Release out_ready: remaining results emerge in order with none lost, and op_count ends at 4.
- Illegal op 13 with A=FFFF:
  - result 0000, out_err=1, out_zero=1.
  - A following use_acc PASS returns 0000.
- Reset:
  - Assert rst for 1 cycle with both stages full. The next cycle shows out_valid=0, in_ready=1, acc=0, op_count=0.
  - No stale result appears afterwards.

Source files
------------

// File: rtl/logic_pkg.sv
// Shared opcode encodings and helpers for the pipelined logic unit.
package logic_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_AND         = 4'd0;
    localparam logic [OP_W-1:0] OP_OR          = 4'd1;
    localparam logic [OP_W-1:0] OP_XOR         = 4'd2;
    localparam logic [OP_W-1:0] OP_NOT         = 4'd3;
    localparam logic [OP_W-1:0] OP_NOR         = 4'd4;
    localparam logic [OP_W-1:0] OP_XNOR        = 4'd5;
    localparam logic [OP_W-1:0] OP_NAND        = 4'd6;
    localparam logic [OP_W-1:0] OP_PASS        = 4'd7;
    localparam logic [OP_W-1:0] OP_SHL         = 4'd8;
    localparam logic [OP_W-1:0] OP_SHR         = 4'd9;
    localparam logic [OP_W-1:0] OP_ROL         = 4'd10;
    localparam logic [OP_W-1:0] OP_ROR         = 4'd11;
    localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 4'd12;

    // Opcodes at or above OP_ILLEGAL_MIN are reserved and flag an error.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op < OP_ILLEGAL_MIN);
    endfunction

endpackage

// File: rtl/logic_unit_core.sv
// Combinational datapath: bitwise ops, logical shifts and rotates on (op, a, b).
module logic_unit_core
    import logic_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic [W-1:0]    result_c,
    output logic            err_c
);

    localparam int unsigned SH_W = $clog2(W);

    logic [SH_W-1:0] sh;
    logic [SH_W:0]   inv_sh;
    logic [W-1:0]    rol_c;
    logic [W-1:0]    ror_c;

    // Shift amount is B mod W; rotates combine two opposite shifts (a shift by W yields 0).
    always_comb begin
        sh     = b[SH_W-1:0];
        inv_sh = (SH_W+1)'(W) - {1'b0, sh};
        rol_c  = (a << sh) | (a >> inv_sh);
        ror_c  = (a >> sh) | (a << inv_sh);
    end

    // Opcode decode; reserved opcodes produce zero with the error flag set.
    always_comb begin
        result_c = '0;
        err_c    = !is_legal_op(op);
        case (op)
            OP_AND:  result_c = a & b;
            OP_OR:   result_c = a | b;
            OP_XOR:  result_c = a ^ b;
            OP_NOT:  result_c = ~a;
            OP_NOR:  result_c = ~(a | b);
            OP_XNOR: result_c = ~(a ^ b);
            OP_NAND: result_c = ~(a & b);
            OP_PASS: result_c = a;
            OP_SHL:  result_c = a << sh;
            OP_SHR:  result_c = a >> sh;
            OP_ROL:  result_c = rol_c;
            OP_ROR:  result_c = ror_c;
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic unit with valid/ready handshake, accumulator chaining
// and a completed-transaction counter.
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
    output logic             out_err,
    output logic [CNT_W-1:0] op_count
);

    logic            s1_valid;
    logic [OP_W-1:0] s1_op;
    logic [W-1:0]    s1_a;
    logic [W-1:0]    s1_b;
    logic            s1_use_acc;
    logic [W-1:0]    acc;

    logic            s2_adv;
    logic            s1_adv;
    logic            in_fire;
    logic            out_fire;
    logic [W-1:0]    a_eff;
    logic [W-1:0]    core_result;
    logic            core_err;

    // Handshake: S2 frees when empty or drained; S1 accepts when empty or advancing.
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = s1_valid && s2_adv;
        in_ready = !s1_valid || s2_adv;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        a_eff    = s1_use_acc ? acc : s1_a;
    end

    logic_unit_core #(
        .W (W)
    ) u_core (
        .op       (s1_op),
        .a        (a_eff),
        .b        (s1_b),
        .result_c (core_result),
        .err_c    (core_err)
    );

    // Stage 1: capture the request operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_op      <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_use_acc <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_fire) begin
                s1_op      <= in_op;
                s1_a       <= in_a;
                s1_b       <= in_b;
                s1_use_acc <= in_use_acc;
            end
        end
    end

    // Stage 2: register result, flags and accumulator; hold everything under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b1;
            out_ones   <= 1'b0;
            out_parity <= 1'b0;
            out_err    <= 1'b0;
            acc        <= '0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
            end
            if (s1_adv) begin
                out_result <= core_result;
                out_zero   <= (core_result == '0);
                out_ones   <= (core_result == '1);
                out_parity <= ^core_result;
                out_err    <= core_err;
                acc        <= core_result;
            end
        end
    end

    // Count results accepted by the consumer, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (out_fire) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (W=16, CNT_W=16).
module tb_logic_unit_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_use_acc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_zero;
    logic        out_ones;
    logic        out_parity;
    logic        out_err;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_bw [0:6] = '{16'h0303, 16'hFFFF, 16'hFCFC, 16'h5454,
                                  16'h0000, 16'h0303, 16'hFCFC};

    logic_unit_pipe #(
        .W     (16),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_use_acc (in_use_acc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_ones   (out_ones),
        .out_parity (out_parity),
        .out_err    (out_err),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic ua);
        in_valid   = 1'b1;
        in_op      = op;
        in_a       = a;
        in_b       = b;
        in_use_acc = ua;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_use_acc = 1'b0;
    endtask

    // Single isolated transaction; leaves the result on the outputs, not yet consumed.
    task automatic run1(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic ua, input logic [15:0] exp);
        drive(op, a, b, ua);
        step();
        idle();
        step();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, 32'(out_result), 32'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_op      = 4'd0;
        in_a       = 16'h0;
        in_b       = 16'h0;
        in_use_acc = 1'b0;
        out_ready  = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_result",    32'(out_result), 32'h0);
        chk("rst_zero",      32'(out_zero),  32'd1);
        chk("rst_ones",      32'(out_ones),  32'd0);
        chk("rst_err",       32'(out_err),   32'd0);
        chk("rst_count",     32'(op_count),  32'd0);
        rst = 1'b0;

        // Bitwise ops 0..6 back-to-back, one result per cycle
        for (int i = 0; i < 7; i++) begin
            drive(4'(i), 16'hABAB, 16'h5757, 1'b0);
            step();
            if (i > 0) begin
                chk("bw_valid", 32'(out_valid), 32'd1);
                chk("bw_result", 32'(out_result), 32'(exp_bw[i-1]));
                chk("bw_ones", 32'(out_ones), 32'(i - 1 == 1));
                chk("bw_zero", 32'(out_zero), 32'(i - 1 == 4));
            end
        end
        idle();
        step();
        chk("bw_nand", 32'(out_result), 32'hFCFC);
        step();
        chk("bw_drained", 32'(out_valid), 32'd0);
        chk("bw_count", 32'(op_count), 32'd7);

        // Shifts and rotates
        run1("shl1", 4'd8, 16'h8001, 16'd1, 1'b0, 16'h0002);
        chk("shl1_parity", 32'(out_parity), 32'd1);
        step();
        run1("rol1", 4'd10, 16'h8001, 16'd1, 1'b0, 16'h0003);
        step();
        run1("ror17", 4'd11, 16'h8001, 16'd17, 1'b0, 16'hC000);
        chk("ror17_parity", 32'(out_parity), 32'd0);
        step();
        run1("shr0", 4'd9, 16'h8001, 16'd0, 1'b0, 16'h8001);
        step();
        run1("shl15", 4'd8, 16'h8001, 16'd15, 1'b0, 16'h8000);
        step();
        run1("shr15", 4'd9, 16'h8001, 16'hFFEF, 1'b0, 16'h0001);
        step();
        run1("ror0", 4'd11, 16'h8001, 16'h0010, 1'b0, 16'h8001);
        step();

        // Accumulator chaining, back-to-back with no stall
        drive(4'd7, 16'h00F0, 16'h0000, 1'b0);
        step();
        drive(4'd1, 16'h1234, 16'h000F, 1'b1);
        chk("chain_ready1", 32'(in_ready), 32'd1);
        step();
        drive(4'd2, 16'h5678, 16'h00FF, 1'b1);
        chk("chain_ready2", 32'(in_ready), 32'd1);
        chk("chain_pass", 32'(out_result), 32'h00F0);
        step();
        idle();
        chk("chain_or", 32'(out_result), 32'h00FF);
        step();
        chk("chain_xor", 32'(out_result), 32'h0000);
        chk("chain_xor_zero", 32'(out_zero), 32'd1);
        step();

        // Backpressure: 5 cycles with out_ready low while streaming 4 PASS requests
        do_reset();
        out_ready = 1'b0;
        drive(4'd7, 16'h0001, 16'h0, 1'b0);
        step();
        drive(4'd7, 16'h0002, 16'h0, 1'b0);
        step();
        chk("bp_ready_low", 32'(in_ready), 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_hold0", 32'(out_result), 32'h0001);
        drive(4'd7, 16'h0003, 16'h0, 1'b0);
        step();
        chk("bp_hold1", 32'(out_result), 32'h0001);
        step();
        chk("bp_hold2", 32'(out_result), 32'h0001);
        step();
        chk("bp_hold3", 32'(out_result), 32'h0001);
        chk("bp_count_held", 32'(op_count), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_release", 32'(in_ready), 32'd1);
        step();
        chk("bp_out2", 32'(out_result), 32'h0002);
        drive(4'd7, 16'h0004, 16'h0, 1'b0);
        step();
        chk("bp_out3", 32'(out_result), 32'h0003);
        idle();
        step();
        chk("bp_out4", 32'(out_result), 32'h0004);
        chk("bp_valid4", 32'(out_valid), 32'd1);
        step();
        chk("bp_done", 32'(out_valid), 32'd0);
        chk("bp_count", 32'(op_count), 32'd4);

        // Illegal opcode zeroes the result and the accumulator
        run1("illegal", 4'd13, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000);
        chk("illegal_err", 32'(out_err), 32'd1);
        chk("illegal_zero", 32'(out_zero), 32'd1);
        step();
        run1("after_illegal", 4'd7, 16'hBEEF, 16'h0, 1'b1, 16'h0000);
        chk("after_illegal_err", 32'(out_err), 32'd0);
        step();

        // Reset with both stages full discards in-flight work
        run1("preload_acc", 4'd7, 16'h1234, 16'h0, 1'b0, 16'h1234);
        step();
        out_ready = 1'b0;
        drive(4'd7, 16'hAAAA, 16'h0, 1'b0);
        step();
        drive(4'd7, 16'h5555, 16'h0, 1'b0);
        step();
        chk("full_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        out_ready = 1'b1;
        drive(4'd7, 16'h7777, 16'h0, 1'b0);
        step();
        rst = 1'b0;
        idle();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_count", 32'(op_count), 32'd0);
        chk("mid_rst_result", 32'(out_result), 32'h0);
        step();
        chk("no_stale1", 32'(out_valid), 32'd0);
        step();
        chk("no_stale2", 32'(out_valid), 32'd0);
        run1("acc_cleared", 4'd7, 16'hFFFF, 16'h0, 1'b1, 16'h0000);
        step();
        chk("final_count", 32'(op_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
